// File: rtl/fib_stream_pkg.sv
// Shared types and constants for the fib_stream generator.
package fib_stream_pkg;

  localparam int ORDER_MIN = 2;
  localparam int ORDER_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fib_sum.sv
// ORDER-input modular adder; o_carry flags any carry out of DATA_WIDTH bits.
module fib_sum #(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2
) (
  input  logic [DATA_WIDTH-1:0] i_terms [ORDER],
  output logic [DATA_WIDTH-1:0] o_sum,
  output logic                  o_carry
);

  // Two guard bits hold the carry of up to four terms.
  logic [DATA_WIDTH+1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < ORDER; k++) begin
      w_acc = w_acc + {2'b00, i_terms[k]};
    end
  end

  assign o_sum   = w_acc[DATA_WIDTH-1:0];
  assign o_carry = |w_acc[DATA_WIDTH+1:DATA_WIDTH];

endmodule

// File: rtl/fib_stream.sv
// Streams an ORDER-term Fibonacci-style sequence over a valid/ready port.
// Optional wrap detection is enabled with macro FIB_STREAM_OVF_DETECT_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs idle
// RUN   | presenting oldest window slot; advances on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module fib_stream
  import fib_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ORDER      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  num_terms,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
    $error("fib_stream: ORDER must be within 2..4");
  end

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_win [ORDER];
  logic [CNT_WIDTH-1:0]  r_index;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_start;

  assign w_hs    = (r_state == RUN) && out_ready;
  assign w_last  = (r_index == r_num - CNT_WIDTH'(1));
  assign w_start = (r_state == IDLE) && start && (num_terms != '0);

  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (num_terms != '0) ? RUN : DONE;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (w_hs && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_num   <= '0;
      for (int k = 0; k < ORDER; k++) r_win[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_num   <= num_terms;
        r_index <= '0;
        for (int k = 0; k < ORDER; k++) r_win[k] <= seed;
      end else if (w_hs) begin
        r_index <= r_index + CNT_WIDTH'(1);
        for (int k = 0; k < ORDER - 1; k++) r_win[k] <= r_win[k+1];
        r_win[ORDER-1] <= w_sum;
      end
    end
  end

  assign out_data  = r_win[0];
  assign out_index = r_index;

`ifdef FIB_STREAM_OVF_DETECT_EN
  logic             w_carry;
  logic [ORDER-1:0] r_tag;
  logic             r_ovf;

  fib_sum #(.DATA_WIDTH(DATA_WIDTH), .ORDER(ORDER)) u_sum (
    .i_terms (r_win),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Tags shift alongside the window; the flag rises when a tagged term leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_tag <= '0;
      r_ovf <= 1'b0;
    end else if (w_hs) begin
      r_tag <= {w_carry, r_tag[ORDER-1:1]};
      if (r_tag[0]) r_ovf <= 1'b1;
    end
  end

  assign overflow = r_ovf;
`else
  logic w_unused_carry;

  fib_sum #(.DATA_WIDTH(DATA_WIDTH), .ORDER(ORDER)) u_sum (
    .i_terms (r_win),
    .o_sum   (w_sum),
    .o_carry (w_unused_carry)
  );

  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fib_stream.sv
// Directed bench for fib_stream: three parameter sets driven in lockstep.
module tb_fib_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] seed;
  logic [15:0] num_terms;
  logic        out_ready;

  logic        v2, b2, d2, o2;
  logic [31:0] data2;
  logic [15:0] idx2;
  logic        v3, b3, d3, o3;
  logic [31:0] data3;
  logic [15:0] idx3;
  logic        v8, b8, d8, o8;
  logic [7:0]  data8;
  logic [15:0] idx8;

  int checks = 0;
  int errors = 0;

`ifdef FIB_STREAM_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  fib_stream #(.DATA_WIDTH(32), .ORDER(2), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_terms(num_terms),
    .out_valid(v2), .out_ready(out_ready), .out_data(data2), .out_index(idx2),
    .busy(b2), .done(d2), .overflow(o2));

  fib_stream #(.DATA_WIDTH(32), .ORDER(3), .CNT_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .num_terms(num_terms),
    .out_valid(v3), .out_ready(out_ready), .out_data(data3), .out_index(idx3),
    .busy(b3), .done(d3), .overflow(o3));

  fib_stream #(.DATA_WIDTH(8), .ORDER(2), .CNT_WIDTH(16)) dut8 (
    .clk(clk), .reset(reset), .start(start), .seed(seed[7:0]), .num_terms(num_terms),
    .out_valid(v8), .out_ready(out_ready), .out_data(data8), .out_index(idx8),
    .busy(b8), .done(d8), .overflow(o8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp2 [8];
    logic [31:0] exp3 [8];
    logic [7:0]  exp8 [15];
    logic [31:0] exps [4];
    exp2 = '{1, 1, 2, 3, 5, 8, 13, 21};
    exp3 = '{1, 1, 1, 3, 5, 9, 17, 31};
    exp8 = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    exps = '{2, 2, 4, 6};

    reset = 1'b1; start = 1'b0; seed = '0; num_terms = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", v2, 0);
    chk("rst_busy", b2, 0);
    chk("rst_done", d2, 0);
    chk("rst_data", data2, 0);
    chk("rst_index", idx2, 0);
    chk("rst_ovf", o8, 0);

    // Full-rate run, ORDER 2 and 3 together.
    start = 1'b1; seed = 32'd1; num_terms = 16'd8; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("o2_valid[%0d]", i), v2, 1);
      chk($sformatf("o2_busy[%0d]", i), b2, 1);
      chk($sformatf("o2_data[%0d]", i), data2, exp2[i]);
      chk($sformatf("o2_index[%0d]", i), idx2, i);
      chk($sformatf("o3_data[%0d]", i), data3, exp3[i]);
      chk($sformatf("o2_done_low[%0d]", i), d2, 0);
      tick();
    end
    chk("o2_done_pulse", d2, 1);
    chk("o2_valid_in_done", v2, 0);
    chk("o3_done_pulse", d3, 1);
    tick();
    chk("o2_done_cleared", d2, 0);
    chk("o2_idle_valid", v2, 0);

    // Stalled run; start pulses during RUN must be ignored.
    start = 1'b1; seed = 32'd1; num_terms = 16'd8; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b0;
      start = 1'b1; seed = 32'd7; num_terms = 16'd3;
      chk($sformatf("stall_data[%0d]", i), data2, exp2[i]);
      chk($sformatf("stall_index[%0d]", i), idx2, i);
      tick();
      start = 1'b0;
      chk($sformatf("stall_hold_data[%0d]", i), data2, exp2[i]);
      chk($sformatf("stall_hold_index[%0d]", i), idx2, i);
      chk($sformatf("stall_hold_valid[%0d]", i), v2, 1);
      out_ready = 1'b1;
      tick();
    end
    chk("stall_done_pulse", d2, 1);
    out_ready = 1'b0;
    tick();
    chk("stall_done_cleared", d2, 0);

    // 8-bit wrap with sticky overflow.
    start = 1'b1; seed = 32'd1; num_terms = 16'd15; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("w8_data[%0d]", i), data8, exp8[i]);
      chk($sformatf("w8_ovf[%0d]", i), o8, OVF_ON && (i >= 14));
      chk($sformatf("o2_no_ovf[%0d]", i), o2, 0);
      tick();
    end
    chk("w8_done", d8, 1);
    chk("w8_ovf_sticky_done", o8, OVF_ON);
    tick();
    chk("w8_ovf_sticky_idle", o8, OVF_ON);

    // Mid-run reset, then a fresh sequence from seed 2.
    start = 1'b1; seed = 32'd1; num_terms = 16'd8; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clears_ovf", o8, 0);
    tick(); tick(); tick(); tick();
    chk("pre_reset_index", idx2, 4);
    chk("pre_reset_data", data2, 5);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("mid_rst_valid", v2, 0);
    chk("mid_rst_busy", b2, 0);
    chk("mid_rst_done", d2, 0);
    chk("mid_rst_data", data2, 0);
    chk("mid_rst_index", idx2, 0);
    chk("mid_rst_data3", data3, 0);
    tick();
    chk("mid_rst_stays_idle", v2, 0);
    start = 1'b1; seed = 32'd2; num_terms = 16'd4; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_data[%0d]", i), data2, exps[i]);
      chk($sformatf("s2_index[%0d]", i), idx2, i);
      tick();
    end
    chk("s2_done", d2, 1);
    tick();

    // Zero-length request.
    start = 1'b1; num_terms = 16'd0;
    tick();
    start = 1'b0;
    chk("zero_valid", v2, 0);
    chk("zero_busy", b2, 0);
    chk("zero_done", d2, 1);
    tick();
    chk("zero_done_cleared", d2, 0);
    chk("zero_valid_after", v2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
